mips_fetch_unit: RTL and testbench

- Instruction fetch sequencer that produces the instruction stream consumed by the opcode decoder / control unit.
- Holds the PC and issues single-outstanding read requests to instruction memory.
- Presents each fetched word with split opcode/funct fields under a valid/ready handshake.
- Redirects on taken branches from the execute stage.

---
 rtl/mips_fetch_if.sv | 37 +++
 rtl/mips_fetch_unit.sv | 100 ++++++++++
 tb/tb_mips_fetch_unit.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mips_fetch_if.sv
// Fetch-unit bus bundle: instruction-memory request channel, execute-stage
// redirect, and the instruction handshake towards the decoder.
//   master : fetch unit side (drives imem_req/imem_addr and the instruction outputs)
//   slave  : environment side (memory, execute stage, decoder)
// Signals:
//   imem_req, imem_addr, imem_ready, imem_rdata   instruction memory read channel
//   branch_taken, branch_target                   redirect from execute stage
//   id_ready, instr_valid, instr, opcode, funct,
//   pc_out                                        instruction handshake to decode
//   stall_cnt                                     decode-stall counter
interface mips_fetch_if #(
    parameter int unsigned ADDR_W = 32
);
    logic              imem_req;
    logic [ADDR_W-1:0] imem_addr;
    logic              imem_ready;
    logic [31:0]       imem_rdata;
    logic              branch_taken;
    logic [ADDR_W-1:0] branch_target;
    logic              id_ready;
    logic              instr_valid;
    logic [31:0]       instr;
    logic [5:0]        opcode;
    logic [5:0]        funct;
    logic [ADDR_W-1:0] pc_out;
    logic [15:0]       stall_cnt;

    modport master (
        output imem_req, imem_addr, instr_valid, instr, opcode, funct, pc_out, stall_cnt,
        input  imem_ready, imem_rdata, branch_taken, branch_target, id_ready
    );

    modport slave (
        input  imem_req, imem_addr, instr_valid, instr, opcode, funct, pc_out, stall_cnt,
        output imem_ready, imem_rdata, branch_taken, branch_target, id_ready
    );
endinterface

// File: rtl/mips_fetch_unit.sv
// Instruction fetch sequencer: holds the PC, issues one outstanding read to
// instruction memory at a time, and presents each fetched word to the decoder
// under a valid/ready handshake. Taken branches redirect the PC from any state.
// Ports:
//   clk  rising-edge clock
//   rst  asynchronous active-high reset
//   bus  mips_fetch_if.master (memory channel, redirect, decode handshake)
// Optional build macro FETCH_STALL_CNT_EN: when defined, stall_cnt counts
// cycles with a held instruction the decoder refuses (saturating); otherwise
// stall_cnt is tied to zero.
module mips_fetch_unit #(
    parameter int unsigned       ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int unsigned       PC_INC   = 4
) (
    input  logic          clk,
    input  logic          rst,
    mips_fetch_if.master  bus
);

    typedef enum logic {
        S_REQ  = 1'b0,
        S_HOLD = 1'b1
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [ADDR_W-1:0] pc;
    logic [31:0]       instr_q;
    logic [ADDR_W-1:0] pc_out_q;
    logic              valid_q;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_REQ;
        else     state <= state_nxt;
    end

    // Next-state logic; a redirect overrides any handshake in the same cycle
    always_comb begin
        state_nxt = state;
        case (state)
            S_REQ:   if (bus.imem_ready) state_nxt = S_HOLD;
            S_HOLD:  if (bus.id_ready)   state_nxt = S_REQ;
            default: state_nxt = S_REQ;
        endcase
        if (bus.branch_taken) state_nxt = S_REQ;
    end

    // Output decode
    always_comb begin
        bus.imem_req = 1'b0;
        if (state == S_REQ) bus.imem_req = 1'b1;
    end

    // PC, captured instruction and its address
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc       <= RESET_PC;
            instr_q  <= '0;
            pc_out_q <= '0;
            valid_q  <= 1'b0;
        end else begin
            valid_q <= (state_nxt == S_HOLD);
            if (bus.branch_taken) begin
                // Word-align the target; any read data this cycle is dropped
                pc <= {bus.branch_target[ADDR_W-1:2], 2'b00};
            end else if (state == S_REQ && bus.imem_ready) begin
                instr_q  <= bus.imem_rdata;
                pc_out_q <= pc;
                pc       <= pc + ADDR_W'(PC_INC);
            end
        end
    end

    assign bus.imem_addr   = pc;
    assign bus.instr_valid = valid_q;
    assign bus.instr       = instr_q;
    assign bus.pc_out      = pc_out_q;
    assign bus.opcode      = instr_q[31:26];
    assign bus.funct       = instr_q[5:0];

`ifdef FETCH_STALL_CNT_EN
    logic [15:0] stall_q;

    // Saturating count of cycles the decoder stalls a valid instruction
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_q <= '0;
        end else if (valid_q && !bus.id_ready && stall_q != 16'hFFFF) begin
            stall_q <= stall_q + 16'd1;
        end
    end

    assign bus.stall_cnt = stall_q;
`else
    assign bus.stall_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_mips_fetch_unit.sv
// Directed self-checking bench for mips_fetch_unit.
module tb_mips_fetch_unit;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    mips_fetch_if #(.ADDR_W(32)) bus ();

    mips_fetch_unit #(
        .ADDR_W  (32),
        .RESET_PC(32'h0000_0000),
        .PC_INC  (4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

`ifdef FETCH_STALL_CNT_EN
    localparam logic [15:0] EXP_STALL = 16'd5;
`else
    localparam logic [15:0] EXP_STALL = 16'd0;
`endif

    // Advance one clock; outputs are sampled and inputs changed 1 time unit after the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.imem_ready = 1'b0;
        bus.imem_rdata = 32'h0;
        bus.branch_taken = 1'b0;
        bus.branch_target = 32'h0;
        bus.id_ready = 1'b0;
        tick();
        tick();
        total++;
        if (bus.imem_req !== 1'b1) begin bad++; $display("FAIL reset_req got=%0b exp=1", bus.imem_req); end
        total++;
        if (bus.imem_addr !== 32'h0) begin bad++; $display("FAIL reset_addr got=%h exp=0", bus.imem_addr); end
        total++;
        if (bus.instr_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%0b exp=0", bus.instr_valid); end
        total++;
        if (bus.instr !== 32'h0 || bus.pc_out !== 32'h0) begin
            bad++; $display("FAIL reset_instr got=%h/%h exp=0/0", bus.instr, bus.pc_out);
        end
        total++;
        if (bus.stall_cnt !== 16'h0) begin bad++; $display("FAIL reset_stall got=%0d exp=0", bus.stall_cnt); end
        rst = 1'b0;
    endtask

    task automatic test_sequential();
        bus.imem_ready = 1'b1;
        bus.imem_rdata = 32'h8C43_0004;
        bus.id_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            total++;
            if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'(4 * k) || bus.instr_valid !== 1'b0) begin
                bad++;
                $display("FAIL seq_req%0d got req=%0b addr=%h valid=%0b exp 1/%h/0",
                         k, bus.imem_req, bus.imem_addr, bus.instr_valid, 32'(4 * k));
            end
            tick();
            total++;
            if (bus.instr_valid !== 1'b1 || bus.imem_req !== 1'b0 || bus.opcode !== 6'b100011 ||
                bus.funct !== 6'b000100 || bus.pc_out !== 32'(4 * k)) begin
                bad++;
                $display("FAIL seq_hold%0d got valid=%0b req=%0b op=%b fn=%b pc_out=%h exp 1/0/100011/000100/%h",
                         k, bus.instr_valid, bus.imem_req, bus.opcode, bus.funct, bus.pc_out, 32'(4 * k));
            end
            tick();
        end
    endtask

    task automatic test_mem_wait();
        rst = 1'b1;
        bus.imem_ready = 1'b0;
        bus.id_ready = 1'b0;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            total++;
            if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h0 || bus.instr_valid !== 1'b0) begin
                bad++;
                $display("FAIL wait%0d got req=%0b addr=%h valid=%0b exp 1/0/0",
                         i, bus.imem_req, bus.imem_addr, bus.instr_valid);
            end
            tick();
        end
        bus.imem_ready = 1'b1;
        bus.imem_rdata = 32'h0085_1020;
        tick();
        bus.imem_ready = 1'b0;
        total++;
        if (bus.instr_valid !== 1'b1 || bus.pc_out !== 32'h0 || bus.instr !== 32'h0085_1020) begin
            bad++;
            $display("FAIL wait_done got valid=%0b pc_out=%h instr=%h exp 1/0/00851020",
                     bus.instr_valid, bus.pc_out, bus.instr);
        end
    endtask

    task automatic test_decode_stall();
        for (int i = 0; i < 5; i++) begin
            total++;
            if (bus.instr_valid !== 1'b1 || bus.funct !== 6'b100000 || bus.instr !== 32'h0085_1020 ||
                bus.imem_req !== 1'b0) begin
                bad++;
                $display("FAIL stall%0d got valid=%0b fn=%b instr=%h req=%0b exp 1/100000/00851020/0",
                         i, bus.instr_valid, bus.funct, bus.instr, bus.imem_req);
            end
            tick();
        end
        total++;
        if (bus.stall_cnt !== EXP_STALL) begin
            bad++; $display("FAIL stall_cnt got=%0d exp=%0d", bus.stall_cnt, EXP_STALL);
        end
        bus.id_ready = 1'b1;
        tick();
        total++;
        if (bus.instr_valid !== 1'b0 || bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h4) begin
            bad++;
            $display("FAIL stall_release got valid=%0b req=%0b addr=%h exp 0/1/4",
                     bus.instr_valid, bus.imem_req, bus.imem_addr);
        end
    endtask

    task automatic test_branch_hold();
        bus.id_ready = 1'b0;
        bus.imem_ready = 1'b1;
        bus.imem_rdata = 32'h2108_FFFF;
        tick();
        bus.branch_taken = 1'b1;
        bus.branch_target = 32'h0000_0043;
        bus.id_ready = 1'b1;
        tick();
        bus.branch_taken = 1'b0;
        bus.imem_ready = 1'b0;
        total++;
        if (bus.instr_valid !== 1'b0 || bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h0000_0040) begin
            bad++;
            $display("FAIL br_hold got valid=%0b req=%0b addr=%h exp 0/1/00000040",
                     bus.instr_valid, bus.imem_req, bus.imem_addr);
        end
    endtask

    task automatic test_branch_resp();
        bus.imem_ready = 1'b1;
        bus.imem_rdata = 32'hDEAD_BEEF;
        bus.branch_taken = 1'b1;
        bus.branch_target = 32'h0000_0100;
        tick();
        total++;
        if (bus.instr_valid !== 1'b0 || bus.imem_addr !== 32'h0000_0100 || bus.instr !== 32'h2108_FFFF) begin
            bad++;
            $display("FAIL br_resp got valid=%0b addr=%h instr=%h exp 0/00000100/2108ffff",
                     bus.instr_valid, bus.imem_addr, bus.instr);
        end
        bus.branch_target = 32'h0000_0200;
        tick();
        bus.branch_target = 32'h0000_0300;
        tick();
        bus.branch_taken = 1'b0;
        total++;
        if (bus.imem_addr !== 32'h0000_0300 || bus.instr_valid !== 1'b0) begin
            bad++;
            $display("FAIL br_b2b got addr=%h valid=%0b exp 00000300/0", bus.imem_addr, bus.instr_valid);
        end
        bus.imem_rdata = 32'h0000_0008;
        bus.id_ready = 1'b1;
        tick();
        total++;
        if (bus.instr_valid !== 1'b1 || bus.pc_out !== 32'h0000_0300 || bus.instr !== 32'h0000_0008) begin
            bad++;
            $display("FAIL br_refetch got valid=%0b pc_out=%h instr=%h exp 1/00000300/00000008",
                     bus.instr_valid, bus.pc_out, bus.instr);
        end
        tick();
    endtask

    task automatic test_wrap();
        bus.imem_ready = 1'b0;
        bus.branch_taken = 1'b1;
        bus.branch_target = 32'hFFFF_FFFE;
        tick();
        bus.branch_taken = 1'b0;
        total++;
        if (bus.imem_addr !== 32'hFFFF_FFFC) begin
            bad++; $display("FAIL wrap_addr got=%h exp=fffffffc", bus.imem_addr);
        end
        bus.imem_ready = 1'b1;
        bus.imem_rdata = 32'h1234_5678;
        bus.id_ready = 1'b0;
        tick();
        total++;
        if (bus.instr_valid !== 1'b1 || bus.pc_out !== 32'hFFFF_FFFC) begin
            bad++;
            $display("FAIL wrap_hold got valid=%0b pc_out=%h exp 1/fffffffc", bus.instr_valid, bus.pc_out);
        end
        bus.id_ready = 1'b1;
        tick();
        total++;
        if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h0) begin
            bad++; $display("FAIL wrap_next got req=%0b addr=%h exp 1/0", bus.imem_req, bus.imem_addr);
        end
    endtask

    task automatic test_async_reset();
        bus.imem_ready = 1'b1;
        bus.imem_rdata = 32'hCAFE_0001;
        bus.id_ready = 1'b0;
        tick();
        bus.imem_ready = 1'b0;
        total++;
        if (bus.instr_valid !== 1'b1 || bus.imem_addr !== 32'h4) begin
            bad++;
            $display("FAIL arst_pre got valid=%0b addr=%h exp 1/4", bus.instr_valid, bus.imem_addr);
        end
        #2;
        rst = 1'b1;
        #1;
        total++;
        if (bus.instr_valid !== 1'b0 || bus.imem_addr !== 32'h0 || bus.imem_req !== 1'b1 ||
            bus.instr !== 32'h0 || bus.pc_out !== 32'h0) begin
            bad++;
            $display("FAIL arst got valid=%0b addr=%h req=%0b instr=%h pc_out=%h exp 0/0/1/0/0",
                     bus.instr_valid, bus.imem_addr, bus.imem_req, bus.instr, bus.pc_out);
        end
        #1;
        rst = 1'b0;
        tick();
    endtask

    initial begin
        total = 0;
        bad = 0;
        rst = 1'b1;
        test_reset();
        test_sequential();
        test_mem_wait();
        test_decode_stall();
        test_branch_hold();
        test_branch_resp();
        test_wrap();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
